// File: rtl/melody_player.sv
// melody_player: plays an eight-note ROM melody as a square wave on tone_out.
// Define MELODY_PLAYER_ABORT_EN to add the abort input that ends playback early.
module melody_player #(
    parameter int CLK_HZ  = 50000000,
    parameter int NOTE_MS = 125,
    parameter int GAP_MS  = 10
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic       loop,
`ifdef MELODY_PLAYER_ABORT_EN
    input  logic       abort,
`endif
    output logic       tone_out,
    output logic [2:0] note_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [31:0] UNIT = 32'(CLK_HZ / 1000 * NOTE_MS);
    localparam logic [31:0] GAPC = 32'(CLK_HZ / 1000 * GAP_MS);

    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

    function automatic logic [25:0] half_of(input logic [2:0] idx);
        case (idx)
            3'd0:    half_of = 26'(CLK_HZ / (2 * 262));
            3'd1:    half_of = 26'(CLK_HZ / (2 * 294));
            3'd2:    half_of = 26'(CLK_HZ / (2 * 330));
            3'd3:    half_of = 26'(CLK_HZ / (2 * 349));
            3'd4:    half_of = 26'(CLK_HZ / (2 * 392));
            3'd5:    half_of = 26'(CLK_HZ / (2 * 440));
            3'd6:    half_of = 26'd0;
            default: half_of = 26'(CLK_HZ / (2 * 523));
        endcase
    endfunction

    function automatic logic [31:0] len_of(input logic [2:0] idx);
        case (idx)
            3'd6:    len_of = UNIT;
            3'd7:    len_of = UNIT << 2;
            default: len_of = UNIT << 1;
        endcase
    endfunction

    state_t      state, state_n;
    logic [31:0] dur_cnt, dur_n;
    logic [25:0] half_cnt, half_n;
    logic [25:0] half;
    logic [31:0] note_len;
    logic        tone_n, busy_n, done_n, adv;
    logic [2:0]  idx_n;

    assign half     = half_of(note_idx);
    assign note_len = len_of(note_idx);

    always_comb begin
        state_n = state;
        dur_n   = dur_cnt + 32'd1;
        half_n  = half_cnt;
        tone_n  = tone_out;
        idx_n   = note_idx;
        done_n  = 1'b0;
        adv     = 1'b0;
        case (state)
            IDLE: begin
                dur_n  = 32'd0;
                half_n = 26'd0;
                tone_n = 1'b0;
                if (start) begin
                    state_n = PLAY;
                    idx_n   = 3'd0;
                end
            end
            PLAY: begin
                // A rest has half == 0 and simply keeps tone_out at its entry value of 0.
                if (half != 26'd0) begin
                    if (half_cnt == half - 26'd1) begin
                        half_n = 26'd0;
                        tone_n = ~tone_out;
                    end else begin
                        half_n = half_cnt + 26'd1;
                    end
                end
                if (dur_cnt == note_len - 32'd1) begin
                    if (GAPC != 32'd0) begin
                        state_n = GAP;
                        dur_n   = 32'd0;
                        half_n  = 26'd0;
                        tone_n  = 1'b0;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            GAP: begin
                tone_n = 1'b0;
                if (dur_cnt == GAPC - 32'd1) adv = 1'b1;
            end
            default: begin
                state_n = IDLE;
                dur_n   = 32'd0;
            end
        endcase

        if (adv) begin
            dur_n  = 32'd0;
            half_n = 26'd0;
            tone_n = 1'b0;
            if (note_idx != 3'd7) begin
                idx_n   = note_idx + 3'd1;
                state_n = PLAY;
            end else if (loop) begin
                idx_n   = 3'd0;
                state_n = PLAY;
            end else begin
                state_n = DONE;
                done_n  = 1'b1;
            end
        end

`ifdef MELODY_PLAYER_ABORT_EN
        if (abort && (state == PLAY || state == GAP)) begin
            state_n = DONE;
            done_n  = 1'b1;
            tone_n  = 1'b0;
            dur_n   = 32'd0;
            half_n  = 26'd0;
        end
`endif

        busy_n = (state_n == PLAY) || (state_n == GAP);
    end

    // Outputs are registered from their next-state values so they line up with state.
    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= IDLE;
            dur_cnt  <= 32'd0;
            half_cnt <= 26'd0;
            tone_out <= 1'b0;
            note_idx <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            dur_cnt  <= dur_n;
            half_cnt <= half_n;
            tone_out <= tone_n;
            note_idx <= idx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: table vectors, directed multi-cycle sequences and random
// stimulus compared each cycle against a position-based melody model.
module tb_melody_player;

    localparam int CLK_HZ   = 8000;
    localparam int NOTE_MS  = 125;
    localparam int GAP_MS   = 10;
    localparam int UNIT     = CLK_HZ / 1000 * NOTE_MS;
    localparam int GAPC     = CLK_HZ / 1000 * GAP_MS;
    localparam int TOTAL    = 17 * UNIT + 8 * GAPC;
    localparam int MAX_MISS = 40;

    logic       clock = 1'b0;
    logic       rst, start, loop;
`ifdef MELODY_PLAYER_ABORT_EN
    logic       abort;
`endif
    logic       tone_out;
    logic [2:0] note_idx;
    logic       busy, done;

    melody_player #(.CLK_HZ(CLK_HZ), .NOTE_MS(NOTE_MS), .GAP_MS(GAP_MS)) dut (
        .clock(clock),
        .rst(rst),
        .start(start),
        .loop(loop),
`ifdef MELODY_PLAYER_ABORT_EN
        .abort(abort),
`endif
        .tone_out(tone_out),
        .note_idx(note_idx),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_miss = 0;

    int freq[8]  = '{262, 294, 330, 349, 392, 440, 0, 523};
    int units[8] = '{2, 2, 2, 2, 2, 2, 1, 4};
    int note_start[8], note_len[8], note_half[8];

    // Model: mode 0 idle, 1 playing at position m_pos within the pass, 2 done pulse.
    int   m_mode = 0;
    int   m_pos = 0;
    logic m_idx_rst = 1'b1;

    // Observation state for directed sequences.
    int   first_busy, last_busy, done_at, done_cnt, busy_cnt, last_tog, note_c0;
    logic prev_busy, prev_tone;
    logic [2:0] prev_idx;
    logic [7:0] seen;

    function automatic logic cur_abort();
`ifdef MELODY_PLAYER_ABORT_EN
        return abort;
`else
        return 1'b0;
`endif
    endfunction

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
            if (n_miss >= MAX_MISS) finish_run();
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_mode    = 0;
            m_idx_rst = 1'b1;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode    = 1;
                    m_pos     = 0;
                    m_idx_rst = 1'b0;
                end
                1: begin
                    if (cur_abort()) m_mode = 2;
                    else if (m_pos == TOTAL - 1) begin
                        if (loop) m_pos = 0;
                        else m_mode = 2;
                    end else m_pos++;
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic model_out(output logic t, output logic [2:0] i, output logic b,
                             output logic d, output logic ic);
        int off;
        t   = 1'b0;
        i   = 3'd0;
        b   = (m_mode == 1);
        d   = (m_mode == 2);
        ic  = m_idx_rst;
        off = 0;
        if (m_mode == 1) begin
            ic = 1'b1;
            for (int k = 0; k < 8; k++)
                if (m_pos >= note_start[k]) begin
                    i   = 3'(k);
                    off = m_pos - note_start[k];
                end
            if (off < note_len[i] && note_half[i] != 0)
                t = ((off / note_half[i]) % 2) == 1;
        end
    endtask

    task automatic step();
        logic t, b, d, ic;
        logic [2:0] i;
        model_step();
        @(posedge clock);
        #1;
        model_out(t, i, b, d, ic);
        check("cycle", int'({tone_out, busy, done, ic ? note_idx : 3'd0}), int'({t, b, d, i}));
    endtask

    task automatic obs_reset();
        first_busy = -1; last_busy = -1; done_at = -1; done_cnt = 0; busy_cnt = 0;
        last_tog = -1; note_c0 = 0; prev_busy = 1'b0; prev_tone = 1'b0; prev_idx = 3'd0;
        seen = 8'd0;
    endtask

    task automatic obs(input int c);
        if (busy) begin
            if (first_busy < 0) first_busy = c;
            last_busy = c;
            busy_cnt++;
            seen[note_idx] = 1'b1;
        end
        if (done) begin
            done_cnt++;
            done_at = c;
        end
        if (busy && (!prev_busy || note_idx != prev_idx)) begin
            note_c0  = c;
            last_tog = c;
        end else if (busy && tone_out != prev_tone && c - note_c0 < 2 * UNIT) begin
            if (note_idx == 3'd0) check("tog_note0", c - last_tog, 15);
            else if (note_idx == 3'd5) check("tog_note5", c - last_tog, 9);
            last_tog = c;
        end
        prev_busy = busy;
        prev_tone = tone_out;
        prev_idx  = note_idx;
    endtask

    typedef struct {
        logic       rst, start, loop;
        logic       tone, busy, done;
        logic [2:0] idx;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int acc;
        rst = 1'b1; start = 1'b0; loop = 1'b0;
`ifdef MELODY_PLAYER_ABORT_EN
        abort = 1'b0;
`endif
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            note_start[k] = acc;
            note_len[k]   = units[k] * UNIT;
            note_half[k]  = (freq[k] != 0) ? CLK_HZ / (2 * freq[k]) : 0;
            acc += note_len[k] + GAPC;
        end

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        for (int v = 0; v < 8; v++) begin
            rst = tbl[v].rst; start = tbl[v].start; loop = tbl[v].loop;
            model_step();
            @(posedge clock);
            #1;
            check($sformatf("tbl[%0d]", v), int'({tone_out, busy, done, note_idx}),
                  int'({tbl[v].tone, tbl[v].busy, tbl[v].done, tbl[v].idx}));
        end

        // Idle with start low.
        rst = 1'b0; start = 1'b0; loop = 1'b0;
        for (int c = 0; c < 100; c++) step();

        // Single pass: start sampled in cycle 0.
        obs_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        obs(1);
        for (int c = 2; c <= TOTAL + 4; c++) begin
            step();
            obs(c);
        end
        check("pass_first_busy", first_busy, 1);
        check("pass_last_busy", last_busy, 17640);
        check("pass_done_at", done_at, 17641);
        check("pass_done_cnt", done_cnt, 1);
        check("pass_notes_seen", int'(seen), 8'hFF);

        // Loop held high: wraps to note 0 with no done pulse.
        obs_reset();
        loop = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        obs(1);
        for (int c = 2; c <= TOTAL + 50; c++) begin
            step();
            obs(c);
            if (c == TOTAL + 1) check("loop_wrap_idx", int'({busy, note_idx}), int'({1'b1, 3'd0}));
        end
        check("loop_done_cnt", done_cnt, 0);
        check("loop_busy_cnt", busy_cnt, TOTAL + 50);
        loop = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Reset in the middle of a note.
        obs_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c < 5000; c++) step();
        rst = 1'b1;
        step();
        check("rst_mid_outputs", int'({tone_out, busy, done, note_idx}), 0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            obs(c);
        end
        check("rst_mid_no_done", done_cnt, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_idx", int'({busy, note_idx}), int'({1'b1, 3'd0}));
        for (int c = 0; c < 300; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;

`ifdef MELODY_PLAYER_ABORT_EN
        // Abort sampled high during cycle 3000.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 3000; c++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_cycle3001", int'({tone_out, busy, done}), int'({1'b0, 1'b0, 1'b1}));
        step();
        check("abort_cycle3002", int'({busy, done}), 0);
        for (int c = 0; c < 10; c++) step();
`endif

        // Random control traffic.
        for (int c = 0; c < 20000; c++) begin
            rst   = ($urandom_range(1999) == 0);
            start = ($urandom_range(49) == 0);
            if ($urandom_range(499) == 0) loop = ~loop;
`ifdef MELODY_PLAYER_ABORT_EN
            abort = ($urandom_range(2999) == 0);
`endif
            step();
        end

        finish_run();
    end

endmodule
